// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode/inc/dec edit FSM that builds a shadow time and loads it into a clock core.
// Define CLOCK_SET_ALARM_EN to add alarm hour/minute editing and the alarm comparator.
module clock_set_ctrl #(
    parameter int TIMEOUT   = 30,
    parameter int ALARM_LEN = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_pls,
    input  logic        inc_pls,
    input  logic        dec_pls,
    input  logic [16:0] watch,
    output logic [4:0]  init_hours,
    output logic [5:0]  init_minutes,
    output logic [5:0]  init_seconds,
    output logic        load,
    output logic        editing,
    output logic [2:0]  sel,
    output logic        alarm
);

    localparam logic [2:0] RUN     = 3'd0;
    localparam logic [2:0] SET_HR  = 3'd1;
    localparam logic [2:0] SET_MIN = 3'd2;
    localparam logic [2:0] SET_SEC = 3'd3;
`ifdef CLOCK_SET_ALARM_EN
    localparam logic [2:0] SET_AH  = 3'd4;
    localparam logic [2:0] SET_AM  = 3'd5;
`endif
    localparam logic [2:0] APPLY   = 3'd6;

    localparam int IW = $clog2(TIMEOUT + 1);

    logic [2:0]    state, next_state;
    logic [IW-1:0] idle_cnt;
    logic [4:0]    shadow_hours;
    logic [5:0]    shadow_minutes, shadow_seconds;
    logic          any_pls, step_en, in_field_state, timed_out;

    assign any_pls        = mode_pls | inc_pls | dec_pls;
    assign step_en        = !mode_pls && (inc_pls ^ dec_pls);
    assign in_field_state = (state != RUN) && (state != APPLY);
    assign timed_out      = in_field_state && !any_pls && (idle_cnt == IW'(TIMEOUT - 1));

    // Modular step: wraps top->0 going up and 0->top going down.
    function automatic logic [5:0] bump(input logic [5:0] v, input logic [5:0] top, input logic up);
        if (up)
            return (v == top) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    always_comb begin
        next_state = state;
        if (timed_out) begin
            next_state = RUN;
        end else begin
            case (state)
                RUN:     if (mode_pls) next_state = SET_HR;
                SET_HR:  if (mode_pls) next_state = SET_MIN;
                SET_MIN: if (mode_pls) next_state = SET_SEC;
`ifdef CLOCK_SET_ALARM_EN
                SET_SEC: if (mode_pls) next_state = SET_AH;
                SET_AH:  if (mode_pls) next_state = SET_AM;
                SET_AM:  if (mode_pls) next_state = APPLY;
`else
                SET_SEC: if (mode_pls) next_state = APPLY;
`endif
                APPLY:   next_state = RUN;
                default: next_state = RUN;
            endcase
        end
    end

    // load is registered off next_state so it coincides exactly with the APPLY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RUN;
            load           <= 1'b0;
            idle_cnt       <= '0;
            shadow_hours   <= '0;
            shadow_minutes <= '0;
            shadow_seconds <= '0;
        end else begin
            state <= next_state;
            load  <= (next_state == APPLY);
            if (any_pls || (next_state != state) || !in_field_state)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + IW'(1);

            if (state == RUN && mode_pls) begin
                shadow_hours   <= watch[16:12];
                shadow_minutes <= watch[11:6];
                shadow_seconds <= watch[5:0];
            end else if (step_en) begin
                case (state)
                    SET_HR:  shadow_hours   <= 5'(bump({1'b0, shadow_hours}, 6'd23, inc_pls));
                    SET_MIN: shadow_minutes <= bump(shadow_minutes, 6'd59, inc_pls);
                    SET_SEC: shadow_seconds <= bump(shadow_seconds, 6'd59, inc_pls);
                    default: ;
                endcase
            end
        end
    end

    assign init_hours   = shadow_hours;
    assign init_minutes = shadow_minutes;
    assign init_seconds = shadow_seconds;
    assign editing      = (state != RUN);
    assign sel          = state;

`ifdef CLOCK_SET_ALARM_EN
    localparam int AW = $clog2(ALARM_LEN + 1);

    logic [4:0]    alarm_h;
    logic [5:0]    alarm_m;
    logic          alarm_q;
    logic [AW-1:0] alarm_cnt;

    // Alarm fires only while running; any pulse or the hold limit silences it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_h   <= 5'd6;
            alarm_m   <= 6'd0;
            alarm_q   <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            if (step_en) begin
                case (state)
                    SET_AH:  alarm_h <= 5'(bump({1'b0, alarm_h}, 6'd23, inc_pls));
                    SET_AM:  alarm_m <= bump(alarm_m, 6'd59, inc_pls);
                    default: ;
                endcase
            end
            if (alarm_q) begin
                if (any_pls || (alarm_cnt == AW'(ALARM_LEN - 1))) begin
                    alarm_q   <= 1'b0;
                    alarm_cnt <= '0;
                end else begin
                    alarm_cnt <= alarm_cnt + AW'(1);
                end
            end else if (state == RUN && watch == {alarm_h, alarm_m, 6'd0}) begin
                alarm_q   <= 1'b1;
                alarm_cnt <= '0;
            end
        end
    end

    assign alarm = alarm_q;
`else
    // No alarm hardware in this build; the comparison folds to constant 0.
    assign alarm = (ALARM_LEN < 0);
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed scoreboard bench for clock_set_ctrl.
// Stimulus pushes expected outputs; a negedge monitor pops and compares them.
module tb_clock_set_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode_pls = 1'b0, inc_pls = 1'b0, dec_pls = 1'b0;
    logic [16:0] watch = '0;
    logic [4:0]  init_hours;
    logic [5:0]  init_minutes, init_seconds;
    logic        load, editing, alarm;
    logic [2:0]  sel;

    clock_set_ctrl #(.TIMEOUT(30), .ALARM_LEN(60)) dut (
        .clk(clk), .rst(rst), .mode_pls(mode_pls), .inc_pls(inc_pls), .dec_pls(dec_pls),
        .watch(watch), .init_hours(init_hours), .init_minutes(init_minutes),
        .init_seconds(init_seconds), .load(load), .editing(editing), .sel(sel), .alarm(alarm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic [2:0] sel;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       ld;
        logic       al;
    } exp_t;
    exp_t sb[$];

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic checkOutput(input string name, input logic [2:0] sel_e, input logic [4:0] h_e,
                               input logic [5:0] m_e, input logic [5:0] s_e, input logic ld_e,
                               input logic al_e);
        logic [22:0] got, want;
        got  = {sel, editing, init_hours, init_minutes, init_seconds, load, alarm};
        want = {sel_e, (sel_e != 3'd0), h_e, m_e, s_e, ld_e, al_e};
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got sel=%0d ed=%0b h=%0d m=%0d s=%0d load=%0b alarm=%0b, want sel=%0d ed=%0b h=%0d m=%0d s=%0d load=%0b alarm=%0b",
                     name, sel, editing, init_hours, init_minutes, init_seconds, load, alarm,
                     sel_e, (sel_e != 3'd0), h_e, m_e, s_e, ld_e, al_e);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                total++;
                bad++;
                $display("[TB] FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else begin
                checkOutput(e.name, e.sel, e.h, e.m, e.s, e.ld, e.al);
            end
        end
    end

    // Drive one cycle of pulses and queue the outputs expected after the next edge.
    task automatic applyStimulus(input logic m, input logic i, input logic d, input string name,
                                 input logic [2:0] sel_e, input int h_e, input int m_e, input int s_e,
                                 input logic ld_e, input logic al_e);
        exp_t e;
        mode_pls = m;
        inc_pls  = i;
        dec_pls  = d;
        e.cyc  = cyc + 1;
        e.name = name;
        e.sel  = sel_e;
        e.h    = 5'(h_e);
        e.m    = 6'(m_e);
        e.s    = 6'(s_e);
        e.ld   = ld_e;
        e.al   = al_e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        mode_pls = 1'b0;
        inc_pls  = 1'b0;
        dec_pls  = 1'b0;
    endtask

    task automatic finishFromSec(input string name, input int h, input int m, input int s);
`ifdef CLOCK_SET_ALARM_EN
        applyStimulus(1, 0, 0, {name, "_ah"}, 3'd4, h, m, s, 0, 0);
        applyStimulus(1, 0, 0, {name, "_am"}, 3'd5, h, m, s, 0, 0);
`endif
        applyStimulus(1, 0, 0, {name, "_apply"}, 3'd6, h, m, s, 1, 0);
        applyStimulus(0, 0, 0, {name, "_run"},   3'd0, h, m, s, 0, 0);
    endtask

    initial begin
        #3;
        checkOutput("reset_hold", 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Hour wrap from 23, field edits, inc+dec cancel, mode beats inc.
        watch = hms(23, 55, 0);
        applyStimulus(1, 0, 0, "t1_enter",      1, 23, 55, 0, 0, 0);
        applyStimulus(0, 1, 0, "t1_inc_wrap",   1, 0, 55, 0, 0, 0);
        applyStimulus(0, 1, 0, "t1_inc2",       1, 1, 55, 0, 0, 0);
        applyStimulus(0, 1, 0, "t1_inc3",       1, 2, 55, 0, 0, 0);
        applyStimulus(1, 0, 0, "t1_to_min",     2, 2, 55, 0, 0, 0);
        applyStimulus(0, 1, 0, "t1_min_inc",    2, 2, 56, 0, 0, 0);
        applyStimulus(1, 0, 0, "t1_to_sec",     3, 2, 56, 0, 0, 0);
        applyStimulus(0, 0, 1, "t1_sec_dec",    3, 2, 56, 59, 0, 0);
        applyStimulus(0, 1, 1, "t1_inc_dec",    3, 2, 56, 59, 0, 0);
`ifdef CLOCK_SET_ALARM_EN
        applyStimulus(1, 1, 0, "t1_mode_inc",   4, 2, 56, 59, 0, 0);
        applyStimulus(1, 0, 0, "t1_am",         5, 2, 56, 59, 0, 0);
        applyStimulus(1, 0, 0, "t1_apply",      6, 2, 56, 59, 1, 0);
`else
        applyStimulus(1, 1, 0, "t1_mode_inc",   6, 2, 56, 59, 1, 0);
`endif
        applyStimulus(0, 0, 0, "t1_run",        0, 2, 56, 59, 0, 0);

        // Minutes 00 down three times to 57 and a full apply.
        watch = hms(12, 0, 34);
        applyStimulus(1, 0, 0, "t2_enter",      1, 12, 0, 34, 0, 0);
        applyStimulus(1, 0, 0, "t2_to_min",     2, 12, 0, 34, 0, 0);
        applyStimulus(0, 0, 1, "t2_dec1",       2, 12, 59, 34, 0, 0);
        applyStimulus(0, 0, 1, "t2_dec2",       2, 12, 58, 34, 0, 0);
        applyStimulus(0, 0, 1, "t2_dec3",       2, 12, 57, 34, 0, 0);
        applyStimulus(1, 0, 0, "t2_to_sec",     3, 12, 57, 34, 0, 0);
        finishFromSec("t2", 12, 57, 34);
        applyStimulus(0, 1, 0, "t2_run_inc",    0, 12, 57, 34, 0, 0);
        applyStimulus(0, 0, 1, "t2_run_dec",    0, 12, 57, 34, 0, 0);

        // Idle timeout abandons the edit without a load.
        watch = hms(7, 8, 9);
        applyStimulus(1, 0, 0, "t3_enter",      1, 7, 8, 9, 0, 0);
        for (int k = 0; k < 29; k++)
            applyStimulus(0, 0, 0, "t3_idle",   1, 7, 8, 9, 0, 0);
        applyStimulus(0, 0, 0, "t3_timeout",    0, 7, 8, 9, 0, 0);
        applyStimulus(0, 0, 0, "t3_no_load",    0, 7, 8, 9, 0, 0);

        // Hour 0-1 and minute 59+1, second 59+1 wraps.
        watch = hms(0, 59, 59);
        applyStimulus(1, 0, 0, "t4_enter",      1, 0, 59, 59, 0, 0);
        applyStimulus(0, 0, 1, "t4_hr_dec",     1, 23, 59, 59, 0, 0);
        applyStimulus(1, 0, 0, "t4_to_min",     2, 23, 59, 59, 0, 0);
        applyStimulus(0, 1, 0, "t4_min_inc",    2, 23, 0, 59, 0, 0);
        applyStimulus(1, 0, 0, "t4_to_sec",     3, 23, 0, 59, 0, 0);
        applyStimulus(0, 1, 0, "t4_sec_inc",    3, 23, 0, 0, 0, 0);
        finishFromSec("t4", 23, 0, 0);

        // Asynchronous reset mid-edit, no clock edge needed.
        watch = hms(10, 20, 30);
        applyStimulus(1, 0, 0, "t5_enter",      1, 10, 20, 30, 0, 0);
        applyStimulus(1, 0, 0, "t5_to_min",     2, 10, 20, 30, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("t5_async_reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("t5_reset_held", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(1, 0, 0, "t5_reenter",    1, 10, 20, 30, 0, 0);

`ifdef CLOCK_SET_ALARM_EN
        // Alarm at 06:01, held 60 cycles, then cleared early by a mode pulse.
        applyStimulus(1, 0, 0, "al_min",        2, 10, 20, 30, 0, 0);
        applyStimulus(1, 0, 0, "al_sec",        3, 10, 20, 30, 0, 0);
        applyStimulus(1, 0, 0, "al_ah",         4, 10, 20, 30, 0, 0);
        applyStimulus(1, 0, 0, "al_am",         5, 10, 20, 30, 0, 0);
        applyStimulus(0, 1, 0, "al_am_inc",     5, 10, 20, 30, 0, 0);
        applyStimulus(1, 0, 0, "al_apply",      6, 10, 20, 30, 1, 0);
        watch = hms(6, 1, 0);
        applyStimulus(0, 0, 0, "al_run",        0, 10, 20, 30, 0, 0);
        applyStimulus(0, 0, 0, "al_rise",       0, 10, 20, 30, 0, 1);
        watch = hms(6, 1, 1);
        for (int k = 0; k < 59; k++)
            applyStimulus(0, 0, 0, "al_hold",   0, 10, 20, 30, 0, 1);
        applyStimulus(0, 0, 0, "al_expire",     0, 10, 20, 30, 0, 0);
        watch = hms(6, 1, 0);
        applyStimulus(0, 0, 0, "al_rise2",      0, 10, 20, 30, 0, 1);
        watch = hms(6, 1, 1);
        applyStimulus(1, 0, 0, "al_mode_clear", 1, 6, 1, 1, 0, 0);
`endif

        for (int k = 0; k < 10 && sb.size() > 0; k++)
            @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: never checked, pending entries=%0d required 0", sb[0].name, sb.size());
            void'(sb.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 30: idle cycles allowed in any edit state before the edit is abandoned.
REQ-002 Parameter ALARM_LEN, default 60: maximum cycles that alarm is held high (used only with ALARM_EN).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 mode_pls  in  1  one-cycle pulse; advances the edit field.
REQ-006 inc_pls  in  1  one-cycle pulse; increments the selected field.
REQ-007 dec_pls  in  1  one-cycle pulse; decrements the selected field.
REQ-008 watch  in  17  live clock time {hours[16:12], minutes[11:6], seconds[5:0]}.
REQ-009 init_hours  out  5  shadow hours presented to the clock core.
REQ-010 init_minutes  out  6  shadow minutes presented to the clock core.
REQ-011 init_seconds  out  6  shadow seconds presented to the clock core.
REQ-012 load  out  1  one-cycle pulse; clock core captures init_* on this pulse.
REQ-013 editing  out  1  high in every state except RUN.
REQ-014 sel  out  3  current state encoding: RUN=0, SET_HR=1, SET_MIN=2, SET_SEC=3, SET_AH=4, SET_AM=5, APPLY=6.
REQ-015 alarm  out  1  alarm indication; constant 0 without ALARM_EN.

Function
REQ-016 FSM transitions on mode_pls: RUN->SET_HR->SET_MIN->SET_SEC->APPLY; with ALARM_EN, SET_SEC->SET_AH->SET_AM->APPLY.
REQ-017 APPLY lasts exactly one cycle, then the FSM returns to RUN unconditionally.
REQ-018 RUN->SET_HR copies watch into the shadow hours/minutes/seconds on the same edge.
REQ-019 load is registered and is high only during the APPLY cycle: exactly one cycle, starting one cycle after the final mode_pls is sampled.
REQ-020 inc_pls/dec_pls change only the selected field, modulo 24 for hours and 60 for minutes/seconds (23+1->0, 0-1->23, 59+1->0, 0-1->59).
REQ-021 Simultaneous inc_pls and dec_pls leave the field unchanged.
REQ-022 mode_pls has priority: when it coincides with inc_pls or dec_pls, the FSM advances and no field changes.
REQ-023 In RUN, inc_pls and dec_pls have no effect on the shadow registers.
REQ-024 Idle counter: reset on any pulse and on entering an edit state; reaching TIMEOUT returns the FSM to RUN with no load, and shadow values are kept but never applied.
REQ-025 init_* always reflect the shadow registers, including outside APPLY.

Reset
REQ-026 Asserting rst (low) at any time, including mid-edit, forces RUN, shadows 0, load 0, editing 0, sel 0, alarm 0, and the idle counter to 0.
REQ-027 With ALARM_EN, alarm hours reset to 6 and alarm minutes to 0.
REQ-028 The first state change after release occurs on the first rising clk edge with rst high.

Configuration
REQ-029 The macro CLOCK_SET_ALARM_EN compiles in the SET_AH/SET_AM states, the alarm registers (hours mod 24, minutes mod 60) and the comparator.
REQ-030 With the macro defined, alarm rises the cycle after watch equals {alarm_h, alarm_m, 0} is sampled in RUN; it stays high until ALARM_LEN cycles elapse or any pulse arrives, and it clears the cycle after that pulse.
REQ-031 Without the macro, SET_SEC->APPLY directly and alarm is tied to 0.

Verification
REQ-032 watch=23:55:00, one mode, then three inc -> sel=1; init_hours wraps 23->0->1->2.
REQ-033 Full sequence with three dec in SET_MIN starting from 00 -> init_minutes=57, load high exactly one cycle, then sel=0.
REQ-034 Enter SET_HR, then 30 idle cycles -> sel returns to 0 and load never pulses.
REQ-035 In SET_SEC, mode and inc in the same cycle -> state advances and init_seconds is unchanged; separately, inc and dec in the same cycle -> no change.
REQ-036 With CLOCK_SET_ALARM_EN, alarm set to 06:01 and watch stepped to 06:01:00 -> alarm high the next cycle and held 60 cycles; a mode pulse clears it early.
REQ-037 rst asserted low while in SET_MIN -> all outputs 0 immediately, with no clock edge required.
